// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and default parameters for the request front end.
// Defines channel FSM states, sense modes and parameter defaults.
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SERVING = 2'd2
   } chan_state_t;

   typedef enum logic {
      EDGE  = 1'b0,
      LEVEL = 1'b1
   } sense_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 8;
   localparam int DEF_WAIT_W          = 16;
   localparam int DEF_MAX_WAIT        = 1000;

endpackage

// File: rtl/request_channel.sv
// request_channel: sync, debounce, trigger, request FSM and wait counter.
// Ports: clock, reset (async low), raw_i, green_i -> req_o, urgent_o, wait_o.
module request_channel
   import traffic_pkg::*;
#(
   parameter sense_t SENSE           = EDGE,
   parameter int     SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int     WAIT_W          = DEF_WAIT_W,
   parameter int     MAX_WAIT        = DEF_MAX_WAIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              raw_i,
   input  logic              green_i,
   output logic              req_o,
   output logic              urgent_o,
   output logic [WAIT_W-1:0] wait_o
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
   localparam logic EDGE_MODE = (SENSE == EDGE);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   c_q, c_d;
   logic                   cp_q;
   logic [DB_W-1:0]        db_q, db_d;
   chan_state_t            state_q, state_d;
   logic                   rearm_q, rearm_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic                   req_q, req_d;
   logic                   urg_q, urg_d;
   logic                   s;
   logic                   trig;

   assign s      = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
   // cp_q holds last cycle's clean level so a rising edge is visible for one cycle
   assign trig   = EDGE_MODE ? (c_q & ~cp_q) : c_q;

   always_comb begin
      db_d = '0;
      c_d  = c_q;
      if (s != c_q) begin
         if (db_q == DB_LAST) begin
            c_d = ~c_q;
         end else begin
            db_d = db_q + 1'b1;
         end
      end
   end

   // Level-sensed channels decide re-request from c at green fall,
   // so rearm only records edge events.
   always_comb begin
      state_d = state_q;
      rearm_d = rearm_q;
      unique case (state_q)
         IDLE: begin
            if (green_i) begin
               state_d = SERVING;
               rearm_d = EDGE_MODE & trig;
            end else if (trig) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (green_i) begin
               state_d = SERVING;
               rearm_d = 1'b0;
            end
         end
         SERVING: begin
            if (!green_i) begin
               state_d = (rearm_q | trig) ? PENDING : IDLE;
               rearm_d = 1'b0;
            end else if (EDGE_MODE & trig) begin
               rearm_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            rearm_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      wait_d = '0;
      if (state_d == PENDING && state_q == PENDING) begin
         wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
      end
      req_d = (state_d == PENDING);
      urg_d = (state_d == PENDING) && (wait_d >= MAX_W);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         c_q     <= 1'b0;
         cp_q    <= 1'b0;
         db_q    <= '0;
         state_q <= IDLE;
         rearm_q <= 1'b0;
         wait_q  <= '0;
         req_q   <= 1'b0;
         urg_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         c_q     <= c_d;
         cp_q    <= c_q;
         db_q    <= db_d;
         state_q <= state_d;
         rearm_q <= rearm_d;
         wait_q  <= wait_d;
         req_q   <= req_d;
         urg_q   <= urg_d;
      end
   end

   assign req_o    = req_q;
   assign urgent_o = urg_q;
   assign wait_o   = wait_q;

endmodule

// File: rtl/request_conditioner.sv
// request_conditioner: conditions raw pedestrian/turn inputs into requests.
// Ports: raw inputs + green feedback in; requests, urgent flags, waits out.
module request_conditioner
   import traffic_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int WAIT_W          = DEF_WAIT_W,
   parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pedestrian_button_raw,
   input  logic              turn_sensor_raw,
   input  logic              pedestrian_green,
   input  logic              turn_green,
   output logic              pedestrian_button,
   output logic              turn_sensor,
   output logic              pedestrian_urgent,
   output logic              turn_urgent,
   output logic [WAIT_W-1:0] pedestrian_wait,
   output logic [WAIT_W-1:0] turn_wait
);

   request_channel #(
      .SENSE           (EDGE),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WAIT_W          (WAIT_W),
      .MAX_WAIT        (MAX_WAIT)
   ) u_ped (
      .clock    (clock),
      .reset    (reset),
      .raw_i    (pedestrian_button_raw),
      .green_i  (pedestrian_green),
      .req_o    (pedestrian_button),
      .urgent_o (pedestrian_urgent),
      .wait_o   (pedestrian_wait)
   );

   request_channel #(
      .SENSE           (LEVEL),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WAIT_W          (WAIT_W),
      .MAX_WAIT        (MAX_WAIT)
   ) u_turn (
      .clock    (clock),
      .reset    (reset),
      .raw_i    (turn_sensor_raw),
      .green_i  (turn_green),
      .req_o    (turn_sensor),
      .urgent_o (turn_urgent),
      .wait_o   (turn_wait)
   );

endmodule

// File: tb/tb_request_conditioner.sv
// tb_request_conditioner: directed + random checks against a cycle model.
// Model follows the request rules directly, sampled at each rising edge.
module tb_request_conditioner;

   localparam int SYNC  = 2;
   localparam int DEB   = 8;
   localparam int WW    = 16;
   localparam int MAXW  = 1000;
   localparam int MAXT  = MAXW % (1 << WW);
   localparam int WSAT  = (1 << WW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic ped_raw = 1'b0;
   logic turn_raw = 1'b0;
   logic ped_green = 1'b0;
   logic turn_green = 1'b0;
   logic pb, ts, pu, tu;
   logic [WW-1:0] pw, tw;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      int          st;
      bit          c;
      bit          cp;
      int          cnt;
      bit          rearm;
      int          wt;
      logic [31:0] hist;
   } mst_t;

   mst_t mp, mt;

   request_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .WAIT_W          (WW),
      .MAX_WAIT        (MAXW)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .pedestrian_button_raw (ped_raw),
      .turn_sensor_raw       (turn_raw),
      .pedestrian_green      (ped_green),
      .turn_green            (turn_green),
      .pedestrian_button     (pb),
      .turn_sensor           (ts),
      .pedestrian_urgent     (pu),
      .turn_urgent           (tu),
      .pedestrian_wait       (pw),
      .turn_wait             (tw)
   );

   always #5 clock = ~clock;

   function automatic mst_t m_zero();
      mst_t z;
      z.st = 0; z.c = 0; z.cp = 0; z.cnt = 0;
      z.rearm = 0; z.wt = 0; z.hist = '0;
      return z;
   endfunction

   // st: 0 idle, 1 waiting for service, 2 being served
   function automatic mst_t m_next(mst_t m, bit raw, bit g, bit lvl);
      mst_t n = m;
      bit s = m.hist[SYNC-1];
      bit rise = m.c && !m.cp;
      bit trig = lvl ? m.c : rise;
      if (m.st == 0) begin
         if (g) begin
            n.st = 2;
            n.rearm = !lvl && rise;
         end else if (trig) begin
            n.st = 1;
            n.wt = 0;
         end
      end else if (m.st == 1) begin
         if (g) begin
            n.st = 2;
            n.wt = 0;
            n.rearm = 0;
         end else if (m.wt < WSAT) begin
            n.wt = m.wt + 1;
         end
      end else begin
         if (!g) begin
            n.st = (m.rearm || (lvl && m.c) || (!lvl && rise)) ? 1 : 0;
            n.rearm = 0;
            n.wt = 0;
         end else if (!lvl && rise) begin
            n.rearm = 1;
         end
      end
      n.cp = m.c;
      if (s != m.c) begin
         n.cnt = m.cnt + 1;
         if (n.cnt == DEB) begin
            n.c = !m.c;
            n.cnt = 0;
         end
      end else begin
         n.cnt = 0;
      end
      n.hist = {m.hist[30:0], raw};
      return n;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mp <= m_zero();
         mt <= m_zero();
      end else begin
         mp <= m_next(mp, ped_raw, ped_green, 1'b0);
         mt <= m_next(mt, turn_raw, turn_green, 1'b1);
      end
   end

   function automatic logic [35:0] dut_v();
      return {pb, ts, pu, tu, pw, tw};
   endfunction

   function automatic logic [35:0] mdl_v();
      return {mp.st == 1, mt.st == 1,
              mp.st == 1 && mp.wt >= MAXT,
              mt.st == 1 && mt.wt >= MAXT,
              16'(mp.wt), 16'(mt.wt)};
   endfunction

   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      nchk++;
      if (dut_v() !== 36'h0) begin
         nerr++;
         $display("FAIL reset_async: got %h want 0", dut_v());
      end
      repeat (2) @(negedge clock);
      nchk++;
      if (dut_v() !== 36'h0) begin
         nerr++;
         $display("FAIL reset_hold: got %h want 0", dut_v());
      end
      reset = 1'b1;
      repeat (3) @(negedge clock);
      nchk++;
      if (dut_v() !== mdl_v() || dut_v() !== 36'h0) begin
         nerr++;
         $display("FAIL reset_release: got %h want 0", dut_v());
      end
   endtask

   task automatic test_press_latency();
      ped_raw = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clock);
         nchk++;
         if (pb !== (k >= 11 && k <= 20)) begin
            nerr++;
            $display("FAIL latency edge %0d: got %b want %b",
                     k, pb, (k >= 11 && k <= 20));
         end
         nchk++;
         if (dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL latency_model edge %0d: got %h want %h",
                     k, dut_v(), mdl_v());
         end
         if (k == 20) begin
            nchk++;
            if (pw !== 16'd9) begin
               nerr++;
               $display("FAIL latency_wait9: got %0d want 9", pw);
            end
            ped_green = 1'b1;
         end
         if (k == 21) begin
            nchk++;
            if (pw !== 16'd0) begin
               nerr++;
               $display("FAIL latency_wait0: got %0d want 0", pw);
            end
         end
      end
      ped_green = 1'b0;
      ped_raw = 1'b0;
      repeat (15) begin
         @(negedge clock);
         nchk++;
         if (dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL latency_tail: got %h want %h",
                     dut_v(), mdl_v());
         end
      end
   endtask

   task automatic test_glitch();
      ped_raw = 1'b1;
      turn_raw = 1'b1;
      repeat (5) @(negedge clock);
      ped_raw = 1'b0;
      turn_raw = 1'b0;
      repeat (20) begin
         @(negedge clock);
         nchk++;
         if (dut_v() !== 36'h0 || mdl_v() !== 36'h0) begin
            nerr++;
            $display("FAIL glitch: got %h want 0 (model %h)",
                     dut_v(), mdl_v());
         end
      end
   endtask

   task automatic test_urgent();
      ped_raw = 1'b1;
      repeat (11) @(negedge clock);
      nchk++;
      if (pb !== 1'b1 || pw !== 16'd0) begin
         nerr++;
         $display("FAIL urgent_start: got pb=%b pw=%0d want 1/0", pb, pw);
      end
      ped_raw = 1'b0;
      for (int j = 1; j <= 1005; j++) begin
         @(negedge clock);
         nchk++;
         if (dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL urgent_model j=%0d: got %h want %h",
                     j, dut_v(), mdl_v());
         end
         if (j == 999) begin
            nchk++;
            if (pu !== 1'b0 || pw !== 16'd999) begin
               nerr++;
               $display("FAIL urgent_999: got pu=%b pw=%0d want 0/999",
                        pu, pw);
            end
         end
         if (j == 1000) begin
            nchk++;
            if (pu !== 1'b1 || pw !== 16'd1000) begin
               nerr++;
               $display("FAIL urgent_1000: got pu=%b pw=%0d want 1/1000",
                        pu, pw);
            end
         end
      end
      ped_green = 1'b1;
      @(negedge clock);
      nchk++;
      if (pb !== 1'b0 || pu !== 1'b0 || pw !== 16'd0) begin
         nerr++;
         $display("FAIL urgent_clear: got %b%b %0d want 00 0", pb, pu, pw);
      end
      ped_green = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_turn_level();
      turn_raw = 1'b1;
      repeat (11) @(negedge clock);
      nchk++;
      if (ts !== 1'b1) begin
         nerr++;
         $display("FAIL turn_rise: got %b want 1", ts);
      end
      repeat (5) @(negedge clock);
      turn_green = 1'b1;
      for (int g = 1; g <= 30; g++) begin
         @(negedge clock);
         nchk++;
         if (ts !== 1'b0 || dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL turn_green g=%0d: got %h want %h",
                     g, dut_v(), mdl_v());
         end
      end
      turn_green = 1'b0;
      @(negedge clock);
      nchk++;
      if (ts !== 1'b1) begin
         nerr++;
         $display("FAIL turn_reassert: got %b want 1", ts);
      end
      repeat (3) @(negedge clock);
      turn_green = 1'b1;
      for (int g = 1; g <= 30; g++) begin
         @(negedge clock);
         if (g == 5) turn_raw = 1'b0;
      end
      turn_green = 1'b0;
      repeat (5) begin
         @(negedge clock);
         nchk++;
         if (ts !== 1'b0 || dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL turn_released: got %h want %h (ts 0)",
                     dut_v(), mdl_v());
         end
      end
   endtask

   task automatic test_rearm();
      ped_raw = 1'b1;
      repeat (11) @(negedge clock);
      ped_green = 1'b1;
      ped_raw = 1'b0;
      for (int g = 1; g <= 40; g++) begin
         @(negedge clock);
         nchk++;
         if (pb !== 1'b0 || dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL rearm_serving g=%0d: got %h want %h",
                     g, dut_v(), mdl_v());
         end
         if (g == 15) ped_raw = 1'b1;
      end
      ped_green = 1'b0;
      @(negedge clock);
      nchk++;
      if (pb !== 1'b1) begin
         nerr++;
         $display("FAIL rearm_reassert: got %b want 1", pb);
      end
      ped_green = 1'b1;
      ped_raw = 1'b0;
      repeat (3) @(negedge clock);
      ped_green = 1'b0;
      repeat (15) @(negedge clock);
      nchk++;
      if (pb !== 1'b0 || dut_v() !== mdl_v()) begin
         nerr++;
         $display("FAIL rearm_idle: got %h want %h", dut_v(), mdl_v());
      end
      ped_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         nchk++;
         if (pb !== 1'b0) begin
            nerr++;
            $display("FAIL coinc_pre k=%0d: got %b want 0", k, pb);
         end
      end
      ped_green = 1'b1;
      repeat (5) @(negedge clock);
      nchk++;
      if (pb !== 1'b0 || dut_v() !== mdl_v()) begin
         nerr++;
         $display("FAIL coinc_green: got %h want %h", dut_v(), mdl_v());
      end
      ped_green = 1'b0;
      @(negedge clock);
      nchk++;
      if (pb !== 1'b1) begin
         nerr++;
         $display("FAIL coinc_reassert: got %b want 1", pb);
      end
      ped_green = 1'b1;
      ped_raw = 1'b0;
      repeat (3) @(negedge clock);
      ped_green = 1'b0;
      repeat (15) @(negedge clock);
   endtask

   task automatic test_reset_mid();
      ped_raw = 1'b1;
      repeat (61) @(negedge clock);
      nchk++;
      if (pb !== 1'b1 || pw !== 16'd50) begin
         nerr++;
         $display("FAIL mid_wait50: got pb=%b pw=%0d want 1/50", pb, pw);
      end
      #2 reset = 1'b0;
      #1;
      nchk++;
      if (dut_v() !== 36'h0) begin
         nerr++;
         $display("FAIL mid_async: got %h want 0", dut_v());
      end
      @(negedge clock);
      reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         nchk++;
         if (pb !== (k >= 11) || pw !== 16'(k > 11 ? k - 11 : 0)) begin
            nerr++;
            $display("FAIL mid_relatch k=%0d: got %b/%0d want %b/%0d",
                     k, pb, pw, (k >= 11), (k > 11 ? k - 11 : 0));
         end
      end
      ped_raw = 1'b0;
      ped_green = 1'b1;
      repeat (3) @(negedge clock);
      ped_green = 1'b0;
      repeat (15) @(negedge clock);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         nchk++;
         if (dut_v() !== mdl_v()) begin
            nerr++;
            $display("FAIL random cyc=%0d: got %h want %h",
                     i, dut_v(), mdl_v());
         end
         if ($urandom_range(15) == 0) ped_raw = ~ped_raw;
         if ($urandom_range(15) == 0) turn_raw = ~turn_raw;
         if ($urandom_range(23) == 0) ped_green = ~ped_green;
         if ($urandom_range(23) == 0) turn_green = ~turn_green;
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_urgent();
      test_turn_level();
      test_rearm();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
